// File: rtl/sim_host_pkg.sv
// Shared types and constants for the simulation host monitor.
package sim_host_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Word offsets within the host window, decoded from address bits [3:2]
    localparam logic [1:0] OFS_CHAR = 2'd0;
    localparam logic [1:0] OFS_FINI = 2'd1;
    localparam logic [1:0] OFS_CLR  = 2'd2;

    localparam logic [31:0] FINI_MAGIC_DFLT = 32'h0002_0000;
    localparam logic [7:0]  TIMEOUT_CODE    = 8'hFF;

endpackage

// File: rtl/sim_host_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible whenever o_valid is high.
module sim_host_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/sim_host_monitor.sv
// Host-window snooper: console FIFO, performance counters and finish/timeout
// handling with a console drain before done is raised.
module sim_host_monitor
    import sim_host_pkg::*;
#(
    parameter int unsigned NUM_EV      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter logic [31:0] FINI_MAGIC  = FINI_MAGIC_DFLT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wvalid_i,
    input  logic [31:0]                  waddr_i,
    input  logic [31:0]                  wdata_i,
    input  logic [NUM_EV-1:0]            ev_i,
    input  logic [$clog2(NUM_EV+1)-1:0]  cnt_sel_i,
    output logic [CNT_W-1:0]             cnt_o,
    output logic                         con_valid_o,
    output logic [7:0]                   con_data_o,
    input  logic                         con_ready_i,
    output logic [7:0]                   drop_cnt_o,
    output logic                         fini_o,
    output logic [7:0]                   fini_code_o,
    output logic                         timeout_o
);

    localparam int unsigned SEL_W = $clog2(NUM_EV + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e r_state;
    state_e w_state_nxt;

    logic [CNT_W-1:0] r_cnt [NUM_EV+1];
    logic [CNT_W-1:0] w_cnt_sel;
    logic [7:0]       r_drop;
    logic [7:0]       r_fini_code;
    logic [7:0]       w_code_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             r_fini;

    logic       w_host_wr;
    logic       w_magic;
    logic [1:0] w_ofs;
    logic       w_fini_req;
    logic       w_push_req;
    logic       w_clr;
    logic       w_timeout_hit;
    logic       w_pop;
    logic       w_fifo_valid;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_data;
    logic       w_drop;
    logic       w_unused_addr;

    // Host-window decode; the magic value overrides the offset decode
    assign w_host_wr  = wvalid_i && waddr_i[31] && (r_state == ST_RUN);
    assign w_magic    = (wdata_i == FINI_MAGIC);
    assign w_ofs      = waddr_i[3:2];
    assign w_fini_req = w_host_wr && (w_magic || (w_ofs == OFS_FINI));
    assign w_push_req = w_host_wr && !w_magic && (w_ofs == OFS_CHAR);
    assign w_clr      = w_host_wr && !w_magic && (w_ofs == OFS_CLR);

    assign w_timeout_hit = (TIMEOUT_CYC != 0) && (r_cnt[0] == TO_LAST);

    assign w_unused_addr = ^{waddr_i[30:4], waddr_i[1:0]};

    assign w_pop  = w_fifo_valid && con_ready_i;
    assign w_drop = w_push_req && w_fifo_full && !w_pop;

    sim_host_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push_req),
        .i_data  (wdata_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Counters run only in RUN; clear beats increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i <= NUM_EV; i++) r_cnt[i] <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_clr) begin
                for (int unsigned i = 0; i <= NUM_EV; i++) r_cnt[i] <= '0;
            end else begin
                r_cnt[0] <= r_cnt[0] + CNT_W'(1);
                for (int unsigned i = 1; i <= NUM_EV; i++) begin
                    if (ev_i[i-1]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_cnt_sel = '0;
        for (int unsigned i = 0; i <= NUM_EV; i++) begin
            if (cnt_sel_i == SEL_W'(i)) w_cnt_sel = r_cnt[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_fini_code;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_RUN: begin
                if (w_fini_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_code_nxt  = w_magic ? 8'h00 : wdata_i[7:0];
                end else if (w_timeout_hit) begin
                    w_state_nxt   = ST_DRAIN;
                    w_code_nxt    = TIMEOUT_CODE;
                    w_timeout_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_fini_code <= '0;
            r_timeout   <= 1'b0;
            r_fini      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fini_code <= w_code_nxt;
            r_timeout   <= w_timeout_nxt;
            r_fini      <= (w_state_nxt == ST_DONE);
        end
    end

    assign cnt_o       = w_cnt_sel;
    assign con_valid_o = w_fifo_valid;
    assign con_data_o  = w_fifo_data;
    assign drop_cnt_o  = r_drop;
    assign fini_o      = r_fini;
    assign fini_code_o = r_fini_code;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_sim_host_monitor.sv
// Directed bench for sim_host_monitor: console path, counters, finish and timeout.
module tb_sim_host_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  ev;
    logic [2:0]  cnt_sel;
    logic [31:0] cnt;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic [7:0]  drop_cnt;
    logic        fini;
    logic [7:0]  fini_code;
    logic        timeout;

    logic        rst2;
    logic [31:0] cnt2;
    logic        con_valid2;
    logic [7:0]  con_data2;
    logic [7:0]  drop_cnt2;
    logic        fini2;
    logic [7:0]  fini_code2;
    logic        timeout2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    localparam logic [31:0] MAGIC = 32'h0002_0000;

    always #5 clk = ~clk;

    sim_host_monitor #(.TIMEOUT_CYC(0)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wvalid_i    (wvalid),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .ev_i        (ev),
        .cnt_sel_i   (cnt_sel),
        .cnt_o       (cnt),
        .con_valid_o (con_valid),
        .con_data_o  (con_data),
        .con_ready_i (con_ready),
        .drop_cnt_o  (drop_cnt),
        .fini_o      (fini),
        .fini_code_o (fini_code),
        .timeout_o   (timeout)
    );

    sim_host_monitor #(.TIMEOUT_CYC(50)) u_to (
        .clk_i       (clk),
        .rst_i       (rst2),
        .wvalid_i    (1'b0),
        .waddr_i     (32'h0),
        .wdata_i     (32'h0),
        .ev_i        (4'h0),
        .cnt_sel_i   (3'd0),
        .cnt_o       (cnt2),
        .con_valid_o (con_valid2),
        .con_data_o  (con_data2),
        .con_ready_i (1'b1),
        .drop_cnt_o  (drop_cnt2),
        .fini_o      (fini2),
        .fini_code_o (fini_code2),
        .timeout_o   (timeout2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wvalid = 1'b1;
        waddr  = a;
        wdata  = d;
        tick(1);
        wvalid = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [63:0] exp, input string tag);
        cnt_sel = sel;
        #1;
        chk(tag, 64'(cnt), exp);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        wvalid = 1'b0; waddr = '0; wdata = '0;
        ev = '0; cnt_sel = '0; con_ready = 1'b0;
        tick(2);

        chk("rst_valid",   64'(con_valid), 64'd0);
        chk("rst_drop",    64'(drop_cnt),  64'd0);
        chk("rst_fini",    64'(fini),      64'd0);
        chk("rst_code",    64'(fini_code), 64'd0);
        chk("rst_timeout", 64'(timeout),   64'd0);
        chk("rst_cnt0",    64'(cnt),       64'd0);
        rst = 1'b0;

        // "Hi\n" streamed straight through
        con_ready = 1'b1;
        wr(32'h8000_0000, 32'h48);
        chk("hi_v0", 64'(con_valid), 64'd1);
        chk("hi_d0", 64'(con_data),  64'h48);
        wr(32'h8000_0000, 32'h69);
        chk("hi_d1", 64'(con_data),  64'h69);
        wr(32'h8000_0000, 32'h0A);
        chk("hi_d2", 64'(con_data),  64'h0A);
        tick(1);
        chk("hi_empty", 64'(con_valid), 64'd0);
        chk("hi_drop",  64'(drop_cnt),  64'd0);

        // Overflow: 20 pushes into 16 entries with the sink stalled
        con_ready = 1'b0;
        for (int i = 0; i < 20; i++) wr(32'h8000_0000, 32'h41 + 32'(i));
        chk("ovf_drop",  64'(drop_cnt),  64'd4);
        chk("ovf_valid", 64'(con_valid), 64'd1);
        chk("ovf_head",  64'(con_data),  64'h41);
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_order", 64'(con_data), 64'h41 + 64'(i));
            tick(1);
        end
        chk("ovf_empty", 64'(con_valid), 64'd0);

        // Counter clear and event counting
        wr(32'h8000_0008, 32'h0);
        rd(3'd1, 64'd0, "clr_cnt1");
        ev = 4'b0001;
        tick(100);
        rd(3'd1, 64'd100, "ev_cnt1");
        rd(3'd0, 64'd100, "ev_cnt0");
        wr(32'h8000_0008, 32'h0);
        rd(3'd1, 64'd0, "clr_wins_cnt1");
        rd(3'd0, 64'd0, "clr_wins_cnt0");
        ev = 4'b1010;
        tick(7);
        rd(3'd2, 64'd7, "ev_cnt2");
        rd(3'd4, 64'd7, "ev_cnt4");
        rd(3'd0, 64'd7, "post_clr_cnt0");
        ev = 4'b0000;

        // Finish code 7 with 5 buffered chars and a 50% ready pattern
        con_ready = 1'b0;
        wr(32'h8000_0008, 32'h0);
        for (int i = 0; i < 5; i++) wr(32'h8000_0000, 32'h30 + 32'(i));
        wr(32'h8000_0004, 32'h7);
        for (int i = 0; i < 10; i++) begin
            con_ready = ((i % 2) == 0);
            chk("drain_fini_low", 64'(fini), 64'd0);
            if (con_ready) chk("drain_data", 64'(con_data), 64'h30 + 64'(i / 2));
            tick(1);
        end
        chk("fin_fini",    64'(fini),      64'd1);
        chk("fin_code",    64'(fini_code), 64'd7);
        chk("fin_timeout", 64'(timeout),   64'd0);
        chk("fin_valid",   64'(con_valid), 64'd0);
        rd(3'd0, 64'd6, "fin_frozen_cnt0");
        ev = 4'b0001;
        wr(32'h8000_0000, 32'h55);
        wr(32'h8000_0004, 32'h9);
        chk("done_no_push", 64'(con_valid), 64'd0);
        chk("done_code",    64'(fini_code), 64'd7);
        rd(3'd1, 64'd0, "done_frozen_cnt1");
        ev = 4'b0000;

        // Reset in the middle of a drain discards the FIFO
        rst = 1'b1; tick(1); rst = 1'b0;
        con_ready = 1'b0;
        wr(32'h8000_0000, 32'h61);
        wr(32'h8000_0000, 32'h62);
        wr(32'h8000_0004, 32'h3);
        chk("mid_fini",  64'(fini),      64'd0);
        chk("mid_valid", 64'(con_valid), 64'd1);
        chk("mid_code",  64'(fini_code), 64'd3);
        rst = 1'b1; tick(1);
        chk("mid_rst_valid", 64'(con_valid), 64'd0);
        chk("mid_rst_code",  64'(fini_code), 64'd0);
        chk("mid_rst_fini",  64'(fini),      64'd0);
        rst = 1'b0;

        // Magic value at the clear offset: finish code 0, counters kept
        tick(9);
        wr(32'h8000_0008, MAGIC);
        chk("magic_fini_low", 64'(fini), 64'd0);
        tick(1);
        chk("magic_fini",    64'(fini),      64'd1);
        chk("magic_code",    64'(fini_code), 64'd0);
        chk("magic_timeout", 64'(timeout),   64'd0);
        rd(3'd0, 64'd10, "magic_cnt0");

        // Timeout instance, with a reset partway through the run
        rst2 = 1'b0;
        tick(25);
        rst2 = 1'b1; tick(1);
        chk("to_rst_fini",    64'(fini2),      64'd0);
        chk("to_rst_timeout", 64'(timeout2),   64'd0);
        chk("to_rst_code",    64'(fini_code2), 64'd0);
        chk("to_rst_cnt0",    64'(cnt2),       64'd0);
        rst2 = 1'b0;
        tick(49);
        chk("to_pre_timeout", 64'(timeout2), 64'd0);
        chk("to_pre_cnt0",    64'(cnt2),     64'd49);
        tick(1);
        chk("to_timeout",  64'(timeout2),   64'd1);
        chk("to_code",     64'(fini_code2), 64'hFF);
        chk("to_fini_low", 64'(fini2),      64'd0);
        chk("to_cnt0",     64'(cnt2),       64'd50);
        tick(1);
        chk("to_fini",     64'(fini2), 64'd1);
        chk("to_frozen",   64'(cnt2),  64'd50);
        rst2 = 1'b1; tick(1);
        chk("to_end_fini",    64'(fini2),      64'd0);
        chk("to_end_timeout", 64'(timeout2),   64'd0);
        chk("to_end_code",    64'(fini_code2), 64'd0);
        rst2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sim_host_monitor.md
Name: sim_host_monitor

Overview:
- Parametrised host-interface monitor for CPU simulation and FPGA bring-up.
- Snoops data-bus writes to the host window (address bit 31 set) and buffers console characters in a FIFO with a valid/ready output.
- Keeps NUM_EV performance event counters plus a cycle counter; handles finish, exit code and timeout with an orderly drain before signalling done.
- Instantiated beside the CPU in the simulation top and in main; the bench and the UART bridge consume its outputs.

Parameters:
- NUM_EV, 4: number of event counters; counter index 0 is the cycle counter, indices 1..NUM_EV map to ev_i[0..NUM_EV-1].
- CNT_W, 32: width of every counter, 1..64.
- FIFO_DEPTH, 16: console FIFO entries; power of two, >= 2.
- TIMEOUT_CYC, 0: cycle limit in RUN; 0 disables the timeout.
- FINI_MAGIC, 32'h00020000: write data that requests a finish with code 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wvalid_i  in  1  data-bus write strobe
- waddr_i  in  32  data-bus write address
- wdata_i  in  32  data-bus write data
- ev_i  in  NUM_EV  per-cycle event pulses
- cnt_sel_i  in  $clog2(NUM_EV+1)  counter read select
- cnt_o  out  CNT_W  selected counter value, combinational from registers
- con_valid_o  out  1  console character valid
- con_data_o  out  8  console character
- con_ready_i  in  1  console sink ready
- drop_cnt_o  out  8  saturating count of dropped characters
- fini_o  out  1  simulation done, sticky
- fini_code_o  out  8  exit code
- timeout_o  out  1  finish was caused by the timeout

Behaviour:
- Reset: all counters 0, FIFO empty, con_valid_o=0, drop_cnt_o=0, fini_o=0, fini_code_o=0, timeout_o=0, state RUN. Reset mid-drain discards the FIFO contents.
- Host write: wvalid_i=1 and waddr_i[31]=1. Decode is on waddr_i[3:2]; writes outside the host window are ignored.
  - wdata_i==FINI_MAGIC: finish request with code 0. This takes priority over the address decode.
  - offset 0: push wdata_i[7:0] into the console FIFO.
  - offset 1: finish request with code wdata_i[7:0].
  - offset 2: clear all counters. The clear takes priority over an increment in the same cycle.
  - offset 3: ignored.
- Host writes are acted on only in RUN and ignored in DRAIN and DONE.
- Counters:
  - In RUN, counter 0 increments every cycle.
  - Counter i increments in every cycle where ev_i[i-1]=1.
  - Counters wrap at 2^CNT_W.
  - In DRAIN and DONE all counters are frozen; the request cycle itself is still counted.
- FIFO:
  - Show-ahead: a character written in cycle t appears on con_valid_o/con_data_o at t+1 if the FIFO was empty.
  - Pop when con_valid_o && con_ready_i.
  - A push while full with no pop in the same cycle drops the character and increments drop_cnt_o, saturating at 255.
  - Push and pop in the same cycle when full: the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- FSM:
  - RUN -> DRAIN on a finish request: fini_code_o is latched in the same edge.
  - RUN -> DRAIN on timeout when TIMEOUT_CYC!=0 and counter 0 == TIMEOUT_CYC-1 while in RUN: timeout_o=1 and fini_code_o=8'hFF.
  - If a finish request and the timeout coincide, the finish request wins and timeout_o stays 0.
  - DRAIN -> DONE once the FIFO is empty and con_valid_o=0. An empty FIFO at entry means DONE is reached one cycle after DRAIN.
  - DONE: fini_o=1 and the state is held until rst_i.
- con_valid_o/con_data_o obey a standard valid/ready contract: data stays stable while valid is high and ready is low.

Decomposition:
- Package sim_host_pkg holds:
  - the FSM state enum (RUN, DRAIN, DONE);
  - offset constants OFS_CHAR=0, OFS_FINI=1, OFS_CLR=2;
  - the default FINI_MAGIC and the timeout exit code 8'hFF.
- One sub-module, sim_host_fifo: a parametrised show-ahead synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty.

Test Plan:
- Three char writes to 0x80000000 ('H','i','\n'), con_ready_i=1 -> con_data_o shows 0x48, 0x69, 0x0A on consecutive cycles starting one cycle after the first write; drop_cnt_o=0.
- con_ready_i=0, 20 char writes with FIFO_DEPTH=16 -> 16 characters retained, drop_cnt_o=4. Releasing ready then delivers the first 16 characters in order.
- Write 0x00000007 to 0x80000004 while 5 characters are buffered and ready toggles 50% -> fini_o rises only after the 5th pop, fini_code_o=7, timeout_o=0. Counters are frozen from the cycle after the request.
- Write FINI_MAGIC to 0x80000008 -> finish with code 0, and the counters are not cleared.
- ev_i[0] held high 100 cycles, then a write to offset 2 in the same cycle as an event -> counter 1 reads 0 on the next cycle. Counter 0 keeps counting from 0 after the clear.
- TIMEOUT_CYC=50 with no writes -> DRAIN entered after 50 RUN cycles; fini_o=1, timeout_o=1, fini_code_o=0xFF. Reset in the middle of this sequence returns all outputs to their reset values.
